io_pattern_checker: RTL and testbench
=====================================

Name: io_pattern_checker

Overview:
Receive-side checker for the inter-FPGA IO stress test. It consumes one SDR lane group (for example IL07[24:0] at 50 MHz, or IL07[70:25] at 125 MHz) driven by the transmitting FPGA's 7-word cyclic pattern generator. It hunts for sequence alignment, verifies a full sequence before declaring lock, then counts every mismatched word. Loss of lock is declared after repeated consecutive errors. One instance is used per lane group per clock domain; the outputs go to LEDs and debug headers.

Parameters:
WIDTH, 25, lane group width in bits (1..64)
ERR_CNT_W, 16, width of the saturating error counter
SYNC_LEN, 7, consecutive correct words after P0 that are required to lock (1..14)
LOSS_THRESH, 4, consecutive mismatches while locked that force re-hunt (1..15)

Ports:
CLK  in  1  lane group clock (clk_50 or clk125 from sys_pll)
RST  in  1  asynchronous, active-high reset
data_in  in  WIDTH  raw lane group pins
clr  in  1  synchronous clear of the error statistics
locked  out  1  high while in LOCKED
err_pulse  out  1  one-cycle pulse per mismatched word while locked
err_count  out  ERR_CNT_W  saturating mismatch count
lock_lost  out  1  one-cycle pulse on the LOCKED->HUNT transition
pat_idx  out  3  expected index of the word currently being compared (debug)

Behaviour:
- Patterns P0..P6 are the WIDTH LSBs of these repeated fills, starting at bit 0:
  - P0 0xAA, P1 0x55, P2 0x0F, P3 0xF0, P4 0x00, P5 0xFF (byte fills)
  - P6 0xA0F5 (16-bit fill)
  - The transmitter sends P0..P6, then wraps to P0, one word per cycle.
- RST (async) forces: state=HUNT, data register=0, idx=0, good=0, consec=0, locked=0, err_pulse=0, err_count=0, lock_lost=0, pat_idx=0.
- Pipeline: data_in is registered into din_q (stage 1). Compare results and outputs update at the next edge. A word present at edge n affects locked/err_pulse/err_count after edge n+1.
- pat_idx shows the expected index compared against the current din_q.
- HUNT: if din_q==P0, go to VERIFY with idx=1 and good=0; otherwise stay in HUNT.
- VERIFY:
  - din_q==P[idx]: idx advances (6 wraps to 0) and good increments.
  - When good reaches SYNC_LEN, go to LOCKED; locked rises on the same edge.
  - Mismatch: return to HUNT. The same word is also evaluated as in HUNT, so a P0 restarts VERIFY with idx=1 on the same edge.
- LOCKED: idx always advances; there is no slip correction.
  - Match: consec=0.
  - Mismatch: err_pulse=1, err_count increments and saturates at all-ones, consec increments.
  - When consec reaches LOSS_THRESH, go to HUNT on that edge: locked=0, lock_lost=1 for one cycle, consec=0. The LOSS_THRESH-th mismatch is still counted.
- clr: err_count=0 and consec=0 next edge. State and idx are unaffected. If clr coincides with a mismatch, clr wins (count=0) but err_pulse is still asserted.
- Errors are never counted in HUNT or VERIFY.
- err_count holds its value across loss of lock and re-lock.

Optional Feature:
IO_CHK_FIRST_ERR_CAPTURE_EN — when defined, adds outputs first_err_word[WIDTH] and first_err_idx[3]:
- Captures din_q and the expected idx on the first counted mismatch after reset or clr.
- Holds them until the next RST or clr.
- first_err_valid flags a valid capture; it is 0 after reset.
When the macro is undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package io_stress_pkg:
  - pattern fill constants (byte and 16-bit seeds)
  - NUM_PAT=7
  - state enum {HUNT, VERIFY, LOCKED}
  - function pat_word(idx, width) that builds P[idx]
- The transmit generator is updated to use the same package.
- Sub-module io_err_counter: saturating counter with clr. It is natural to reuse for lock_lost statistics.

Test Plan:
- WIDTH=25: clean P0..P6 stream after reset, RST deasserted at word P3 -> VERIFY entered at P0; locked=1 two cycles after the 7th post-P0 correct word is presented; err_count=0 over 1000 words.
- Locked, inject a single flipped bit in one P2 word -> exactly one err_pulse, 2 cycles later; err_count=1; locked stays 1; pat_idx continues without slip.
- Locked, 4 consecutive corrupted words (LOSS_THRESH=4) -> err_count=4, one lock_lost pulse, locked=0; the clean stream re-locks after the next P0 plus 7 words.
- ERR_CNT_W=4 with 20 isolated errors -> err_count saturates at 15; a clr coincident with an error gives err_count=0 and err_pulse=1.
- RST pulsed mid-LOCKED asynchronously -> all outputs 0 immediately; the checker re-hunts normally.
- Macro defined: first error at expected idx 5 with word 0x1FFFFFE -> first_err_word=0x1FFFFFE, first_err_idx=5; a later error does not overwrite it; clr clears first_err_valid.

Source files
------------

// File: rtl/io_stress_pkg.sv
// io_stress_pkg: shared definitions for the inter-FPGA IO stress test.
// Both the transmit pattern generator and the receive-side checker build
// their 7-word cyclic sequence from the fills defined here, so the two ends
// cannot drift apart.
package io_stress_pkg;

  localparam int NUM_PAT   = 7;
  localparam int PAT_MAX_W = 64;

  // Byte fills for P0..P5; P6 uses a 16-bit seed
  localparam logic [7:0]  FILL_P0 = 8'hAA;
  localparam logic [7:0]  FILL_P1 = 8'h55;
  localparam logic [7:0]  FILL_P2 = 8'h0F;
  localparam logic [7:0]  FILL_P3 = 8'hF0;
  localparam logic [7:0]  FILL_P4 = 8'h00;
  localparam logic [7:0]  FILL_P5 = 8'hFF;
  localparam logic [15:0] FILL_P6 = 16'hA0F5;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Builds P[idx]: the seed is repeated upward from bit 0 and the result is
  // masked to the lane group width. Indices above 6 yield all zeros.
  function automatic logic [PAT_MAX_W-1:0] pat_word(input logic [2:0] idx, input int width);
    logic [PAT_MAX_W-1:0] w;
    logic [7:0]           fill;
    w    = '0;
    fill = '0;
    case (idx)
      3'd0:    fill = FILL_P0;
      3'd1:    fill = FILL_P1;
      3'd2:    fill = FILL_P2;
      3'd3:    fill = FILL_P3;
      3'd4:    fill = FILL_P4;
      3'd5:    fill = FILL_P5;
      default: fill = 8'h00;
    endcase
    if (idx == 3'd6) begin
      for (int i = 0; i < PAT_MAX_W / 16; i++) w[i*16 +: 16] = FILL_P6;
    end else if (idx < 3'd6) begin
      for (int i = 0; i < PAT_MAX_W / 8; i++) w[i*8 +: 8] = fill;
    end
    if (width < PAT_MAX_W) w = w & ((64'd1 << width) - 64'd1);
    return w;
  endfunction

endpackage

// File: rtl/io_err_counter.sv
// io_err_counter: saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping so a long soak never reads as clean.
module io_err_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Count up on inc, stick at all-ones, clear wins over a coincident inc
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/io_pattern_checker.sv
// io_pattern_checker: receive-side checker for one SDR lane group of the
// inter-FPGA IO stress test. Hunts for P0, verifies SYNC_LEN following words,
// then counts every mismatched word while locked. LOSS_THRESH consecutive
// mismatches drop back to hunting.
// Optional build macro: IO_CHK_FIRST_ERR_CAPTURE_EN adds capture of the first
// counted mismatch (first_err_valid / first_err_word / first_err_idx).
module io_pattern_checker
  import io_stress_pkg::*;
#(
  parameter int WIDTH       = 25,
  parameter int ERR_CNT_W   = 16,
  parameter int SYNC_LEN    = 7,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 lock_lost,
  output logic [2:0]           pat_idx
`ifdef IO_CHK_FIRST_ERR_CAPTURE_EN
  ,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_word,
  output logic [2:0]           first_err_idx
`endif
);

  localparam logic [3:0] SYNC_LEN_C    = 4'(SYNC_LEN);
  localparam logic [3:0] LOSS_THRESH_C = 4'(LOSS_THRESH);

  logic [WIDTH-1:0] din_q_reg;
  chk_state_e       state_reg;
  logic [2:0]       idx_reg;
  logic [3:0]       good_reg;
  logic [3:0]       consec_reg;
  logic             locked_reg;
  logic             err_pulse_reg;
  logic             lock_lost_reg;

  logic [WIDTH-1:0] pat_tbl [NUM_PAT];
  logic [7:0]       match_vec;
  logic             word_ok;
  logic             is_p0;
  logic [2:0]       idx_inc;
  logic [3:0]       good_inc;
  logic [3:0]       consec_inc;
  logic             err_inc;

  // Pattern table and one equality comparator per pattern; the expected
  // index then just picks the relevant comparator output.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAT; gi++) begin : g_pat
      localparam logic [PAT_MAX_W-1:0] PAT_FULL = pat_word(3'(gi), WIDTH);
      assign pat_tbl[gi]   = PAT_FULL[WIDTH-1:0];
      assign match_vec[gi] = (din_q_reg == pat_tbl[gi]);
    end
  endgenerate
  // Index 7 is never expected; tie it low so the select stays in range
  assign match_vec[7] = 1'b0;

  assign word_ok    = match_vec[idx_reg];
  assign is_p0      = match_vec[0];
  assign idx_inc    = (idx_reg == 3'd6) ? 3'd0 : idx_reg + 3'd1;
  assign good_inc   = good_reg + 4'd1;
  assign consec_inc = consec_reg + 4'd1;
  // Only mismatches while locked are real link errors
  assign err_inc    = (state_reg == LOCKED) && !word_ok;

  // Stage 1: register the raw lane pins
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) din_q_reg <= '0;
    else     din_q_reg <= data_in;
  end

  // Alignment FSM with registered status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= HUNT;
      idx_reg       <= 3'd0;
      good_reg      <= 4'd0;
      consec_reg    <= 4'd0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      err_pulse_reg <= 1'b0;
      lock_lost_reg <= 1'b0;
      case (state_reg)
        HUNT: begin
          if (is_p0) begin
            state_reg <= VERIFY;
            idx_reg   <= 3'd1;
            good_reg  <= 4'd0;
          end
        end
        VERIFY: begin
          if (word_ok) begin
            idx_reg  <= idx_inc;
            good_reg <= good_inc;
            if (good_inc == SYNC_LEN_C) begin
              state_reg  <= LOCKED;
              locked_reg <= 1'b1;
              consec_reg <= 4'd0;
            end
          end else if (is_p0) begin
            // The breaking word is itself a P0: restart verification here
            idx_reg  <= 3'd1;
            good_reg <= 4'd0;
          end else begin
            state_reg <= HUNT;
            idx_reg   <= 3'd0;
            good_reg  <= 4'd0;
          end
        end
        LOCKED: begin
          // No slip correction: the expected index free-runs once locked
          idx_reg <= idx_inc;
          if (word_ok) begin
            consec_reg <= 4'd0;
          end else begin
            err_pulse_reg <= 1'b1;
            if (consec_inc == LOSS_THRESH_C) begin
              state_reg     <= HUNT;
              idx_reg       <= 3'd0;
              good_reg      <= 4'd0;
              locked_reg    <= 1'b0;
              lock_lost_reg <= 1'b1;
              consec_reg    <= 4'd0;
            end else begin
              consec_reg <= consec_inc;
            end
          end
        end
        default: begin
          state_reg  <= HUNT;
          idx_reg    <= 3'd0;
          good_reg   <= 4'd0;
          consec_reg <= 4'd0;
          locked_reg <= 1'b0;
        end
      endcase
      // Statistics clear also restarts the consecutive-error run
      if (clr) consec_reg <= 4'd0;
    end
  end

  io_err_counter #(
    .W (ERR_CNT_W)
  ) u_err_counter (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (clr),
    .inc   (err_inc),
    .count (err_count)
  );

`ifdef IO_CHK_FIRST_ERR_CAPTURE_EN
  logic             first_err_valid_reg;
  logic [WIDTH-1:0] first_err_word_reg;
  logic [2:0]       first_err_idx_reg;

  // Latch the first counted mismatch; a coincident clr suppresses capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      first_err_valid_reg <= 1'b0;
      first_err_word_reg  <= '0;
      first_err_idx_reg   <= 3'd0;
    end else if (clr) begin
      first_err_valid_reg <= 1'b0;
      first_err_word_reg  <= '0;
      first_err_idx_reg   <= 3'd0;
    end else if (err_inc && !first_err_valid_reg) begin
      first_err_valid_reg <= 1'b1;
      first_err_word_reg  <= din_q_reg;
      first_err_idx_reg   <= idx_reg;
    end
  end

  assign first_err_valid = first_err_valid_reg;
  assign first_err_word  = first_err_word_reg;
  assign first_err_idx   = first_err_idx_reg;
`endif

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign lock_lost = lock_lost_reg;
  assign pat_idx   = idx_reg;

endmodule

// File: tb/tb_io_pattern_checker.sv
// tb_io_pattern_checker: directed bench for io_pattern_checker (WIDTH=25).
// A second instance with a 4-bit error counter shares the stimulus to
// exercise counter saturation.
module tb_io_pattern_checker;

  localparam int W = 25;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         clr = 1'b0;

  logic         locked, err_pulse, lock_lost;
  logic [15:0]  err_count;
  logic [2:0]   pat_idx;
  logic         locked4, err_pulse4, lock_lost4;
  logic [3:0]   err_count4;
  logic [2:0]   pat_idx4;
`ifdef IO_CHK_FIRST_ERR_CAPTURE_EN
  logic         fe_valid, fe_valid4;
  logic [W-1:0] fe_word, fe_word4;
  logic [2:0]   fe_idx, fe_idx4;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int tx_idx       = 0;

  // Hand-computed 25-bit patterns
  logic [W-1:0] pat [7];

  io_pattern_checker #(.WIDTH(W), .ERR_CNT_W(16), .SYNC_LEN(7), .LOSS_THRESH(4)) dut (
    .CLK(CLK), .RST(RST), .data_in(data_in), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .lock_lost(lock_lost), .pat_idx(pat_idx)
`ifdef IO_CHK_FIRST_ERR_CAPTURE_EN
    , .first_err_valid(fe_valid), .first_err_word(fe_word), .first_err_idx(fe_idx)
`endif
  );

  io_pattern_checker #(.WIDTH(W), .ERR_CNT_W(4), .SYNC_LEN(7), .LOSS_THRESH(4)) dut4 (
    .CLK(CLK), .RST(RST), .data_in(data_in), .clr(clr),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4),
    .lock_lost(lock_lost4), .pat_idx(pat_idx4)
`ifdef IO_CHK_FIRST_ERR_CAPTURE_EN
    , .first_err_valid(fe_valid4), .first_err_word(fe_word4), .first_err_idx(fe_idx4)
`endif
  );

  always #5 CLK = ~CLK;

  // Present one word at the negedge; return 1 time unit after the capturing
  // posedge, when outputs reflect the word sent one call earlier.
  task automatic send(input logic [W-1:0] w);
    @(negedge CLK);
    data_in = w;
    tx_idx  = (tx_idx + 1) % 7;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_clean();
    send(pat[tx_idx]);
  endtask

  task automatic send_bad(input logic [W-1:0] flip);
    send(pat[tx_idx] ^ flip);
  endtask

  task automatic align_to(input int k);
    while (tx_idx != k) send_clean();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tx_idx = 0;
    for (int i = 0; i < 3; i++) send_clean();
    tests_run++;
    if ({locked, err_pulse, err_count, lock_lost, pat_idx} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got locked=%0b pulse=%0b cnt=%0d lost=%0b idx=%0d, expected all 0",
               locked, err_pulse, err_count, lock_lost, pat_idx);
    end
    RST = 1'b0;
    $display("[TB] reset: outputs idle, released at P3");
  endtask

  task automatic test_lock_acquire();
    int bad;
    for (int s = 1; s <= 13; s++) begin
      send_clean();
      if (s == 6) begin
        tests_run++;
        if (pat_idx !== 3'd1 || locked !== 1'b0) begin
          tests_failed++;
          $display("FAIL verify_entry: pat_idx=%0d locked=%0b, expected 1 and 0", pat_idx, locked);
        end
      end
      if (s == 12) begin
        tests_run++;
        if (locked !== 1'b0) begin
          tests_failed++;
          $display("FAIL lock_early: locked=%0b expected 0", locked);
        end
      end
    end
    tests_run++;
    if (locked !== 1'b1 || pat_idx !== 3'd1) begin
      tests_failed++;
      $display("FAIL lock_on_time: locked=%0b pat_idx=%0d, expected 1 and 1", locked, pat_idx);
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      send_clean();
      if (locked !== 1'b1 || err_pulse !== 1'b0 || lock_lost !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL clean_soak: bad_cycles=%0d err_count=%0d, expected 0 and 0", bad, err_count);
    end
    $display("[TB] lock_acquire: locked after P0+7, 1000 clean words");
  endtask

  task automatic test_single_error();
    align_to(2);
    send_bad(25'h0000100);
    tests_run++;
    if (err_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_err_early: err_pulse=%0b expected 0", err_pulse);
    end
    send_clean();
    tests_run++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1 || pat_idx !== 3'd3) begin
      tests_failed++;
      $display("FAIL single_err: pulse=%0b cnt=%0d locked=%0b idx=%0d, expected 1 1 1 3",
               err_pulse, err_count, locked, pat_idx);
    end
    send_clean();
    tests_run++;
    if (err_pulse !== 1'b0 || err_count !== 16'd1 || pat_idx !== 3'd4) begin
      tests_failed++;
      $display("FAIL single_err_after: pulse=%0b cnt=%0d idx=%0d, expected 0 1 4",
               err_pulse, err_count, pat_idx);
    end
    $display("[TB] single_error: one pulse, count=1, no slip");
  endtask

  task automatic test_loss_of_lock();
    clr = 1'b1;
    send_clean();
    clr = 1'b0;
    tests_run++;
    if (err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL clr_count: err_count=%0d expected 0", err_count);
    end
    align_to(0);
    for (int i = 0; i < 4; i++) send_bad({W{1'b1}});
    send_clean();
    tests_run++;
    if (err_count !== 16'd4 || lock_lost !== 1'b1 || locked !== 1'b0 || err_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL loss: cnt=%0d lost=%0b locked=%0b pulse=%0b, expected 4 1 0 1",
               err_count, lock_lost, locked, err_pulse);
    end
    for (int s = 1; s <= 11; s++) begin
      send_clean();
      if (s == 1) begin
        tests_run++;
        if (lock_lost !== 1'b0) begin
          tests_failed++;
          $display("FAIL lock_lost_width: lock_lost=%0b expected 0", lock_lost);
        end
      end
      if (s == 10) begin
        tests_run++;
        if (locked !== 1'b0) begin
          tests_failed++;
          $display("FAIL relock_early: locked=%0b expected 0", locked);
        end
      end
    end
    tests_run++;
    if (locked !== 1'b1 || err_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL relock: locked=%0b cnt=%0d, expected 1 and 4", locked, err_count);
    end
    $display("[TB] loss_of_lock: 4 errors, lock_lost, relocked");
  endtask

  task automatic test_async_reset();
    logic [W-1:0] seq [11];
    seq = '{pat[0], pat[1], pat[0], pat[1], pat[2], pat[3], pat[4], pat[5], pat[6], pat[0], pat[1]};
    #1 RST = 1'b1;
    #1;
    tests_run++;
    if ({locked, err_pulse, err_count, lock_lost, pat_idx, locked4, err_count4} !== 27'd0) begin
      tests_failed++;
      $display("FAIL async_reset: locked=%0b pulse=%0b cnt=%0d lost=%0b idx=%0d cnt4=%0d, expected all 0",
               locked, err_pulse, err_count, lock_lost, pat_idx, err_count4);
    end
    #1 RST = 1'b0;
    for (int s = 0; s < 11; s++) begin
      send(seq[s]);
      if (s == 3) begin
        tests_run++;
        if (pat_idx !== 3'd1 || locked !== 1'b0) begin
          tests_failed++;
          $display("FAIL verify_restart: pat_idx=%0d locked=%0b, expected 1 and 0", pat_idx, locked);
        end
      end
      if (s == 9) begin
        tests_run++;
        if (locked !== 1'b0) begin
          tests_failed++;
          $display("FAIL rehunt_early: locked=%0b expected 0", locked);
        end
      end
    end
    tx_idx = 2;
    tests_run++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL rehunt_lock: locked=%0b cnt=%0d, expected 1 and 0", locked, err_count);
    end
    $display("[TB] async_reset: cleared immediately, relocked");
  endtask

  task automatic test_saturation();
    for (int e = 0; e < 20; e++) begin
      send_bad(25'h0000001);
      for (int i = 0; i < 3; i++) send_clean();
    end
    tests_run++;
    if (err_count4 !== 4'd15 || err_count !== 16'd20 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL saturate: cnt4=%0d cnt=%0d locked=%0b, expected 15 20 1",
               err_count4, err_count, locked);
    end
    send_bad(25'h0000001);
    clr = 1'b1;
    send_clean();
    clr = 1'b0;
    tests_run++;
    if (err_count !== 16'd0 || err_pulse !== 1'b1 || err_count4 !== 4'd0 || err_pulse4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_vs_err: cnt=%0d pulse=%0b cnt4=%0d pulse4=%0b, expected 0 1 0 1",
               err_count, err_pulse, err_count4, err_pulse4);
    end
    $display("[TB] saturation: 4-bit count held at 15, clr beats error");
  endtask

`ifdef IO_CHK_FIRST_ERR_CAPTURE_EN
  task automatic test_first_err();
    send_clean();
    tests_run++;
    if (fe_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fe_initial: valid=%0b expected 0", fe_valid);
    end
    align_to(5);
    send(25'h1FFFFFE);
    send_clean();
    tests_run++;
    if (fe_valid !== 1'b1 || fe_word !== 25'h1FFFFFE || fe_idx !== 3'd5) begin
      tests_failed++;
      $display("FAIL fe_capture: valid=%0b word=%h idx=%0d, expected 1 1fffffe 5", fe_valid, fe_word, fe_idx);
    end
    align_to(2);
    send_bad(25'h0000010);
    send_clean();
    tests_run++;
    if (err_pulse !== 1'b1 || fe_word !== 25'h1FFFFFE || fe_idx !== 3'd5) begin
      tests_failed++;
      $display("FAIL fe_hold: pulse=%0b word=%h idx=%0d, expected 1 1fffffe 5", err_pulse, fe_word, fe_idx);
    end
    clr = 1'b1;
    send_clean();
    clr = 1'b0;
    tests_run++;
    if (fe_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fe_clr: valid=%0b expected 0", fe_valid);
    end
    $display("[TB] first_err: captured idx 5, held, cleared");
  endtask
`endif

  initial begin
    pat[0] = 25'h0AAAAAA;
    pat[1] = 25'h1555555;
    pat[2] = 25'h10F0F0F;
    pat[3] = 25'h0F0F0F0;
    pat[4] = 25'h0000000;
    pat[5] = 25'h1FFFFFF;
    pat[6] = 25'h0F5A0F5;
    test_reset();
    test_lock_acquire();
    test_single_error();
    test_loss_of_lock();
    test_async_reset();
    test_saturation();
`ifdef IO_CHK_FIRST_ERR_CAPTURE_EN
    test_first_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
